// File: rtl/sprite_line_ctrl.sv
// Per-scanline sequencer for the sprite pipeline. On each line-end pulse it
// clears the back half of the ping-pong line buffer, starts the sprite
// front-end, waits for the front-end and drawer to finish, and counts render
// overruns (a line-end that arrives before the current line is finished).
module sprite_line_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int V_TOTAL  = 525
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       line_end,
  input  logic [9:0] vcount,
  input  logic       fe_done,
  input  logic       busy,
  input  logic       ovr_clr,
  output logic       start_row,
  output logic [9:0] next_vcount,
  output logic       clr_we,
  output logic [9:0] clr_addr,
  output logic       draw_buf,
  output logic       disp_buf,
  output logic       rendering,
  output logic       overrun,
  output logic [7:0] overrun_cnt
);

  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE - 1);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_START,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] nl;
  logic [9:0] next_vcount_d;
  logic [9:0] clr_addr_d;
  logic       draw_buf_d;
  logic       overrun_d;
  logic [7:0] overrun_cnt_d;

  // Next-state and next-output logic; a line_end always wins over progress.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    state_d       = state_q;
    next_vcount_d = next_vcount;
    draw_buf_d    = draw_buf;
    clr_addr_d    = '0;
    overrun_d     = 1'b0;
    overrun_cnt_d = overrun_cnt;
    nl            = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;

    if (line_end) begin
      // A line_end while still rendering aborts the line and is an overrun.
      overrun_d = (state_q inside {S_CLEAR, S_START, S_ARM, S_RUN});
      if (nl < V_VIS) begin
        next_vcount_d = nl;
        draw_buf_d    = ~draw_buf;
        state_d       = S_CLEAR;
      end else begin
        state_d = S_IDLE;
      end
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_addr == H_LAST) state_d = S_START;
          else                    clr_addr_d = clr_addr + 10'd1;
        end
        S_START: state_d = S_ARM;
        // fe_done is still stale in ARM; the front-end needs a cycle to drop it.
        S_ARM:   state_d = S_RUN;
        S_RUN:   if (fe_done && !busy) state_d = S_DONE;
        default: ;
      endcase
    end

    if (ovr_clr)                              overrun_cnt_d = 8'd0;
    else if (overrun_d && overrun_cnt != 8'hFF) overrun_cnt_d = overrun_cnt + 8'd1;
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_row   <= 1'b0;
      next_vcount <= '0;
      clr_we      <= 1'b0;
      clr_addr    <= '0;
      draw_buf    <= 1'b0;
      disp_buf    <= 1'b1;
      rendering   <= 1'b0;
      overrun     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q     <= state_d;
      start_row   <= (state_d == S_START);
      next_vcount <= next_vcount_d;
      clr_we      <= (state_d == S_CLEAR);
      clr_addr    <= clr_addr_d;
      draw_buf    <= draw_buf_d;
      disp_buf    <= ~draw_buf_d;
      rendering   <= (state_d inside {S_CLEAR, S_START, S_ARM, S_RUN});
      overrun     <= overrun_d;
      overrun_cnt <= overrun_cnt_d;
    end
  end

endmodule
